// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// parity/framing/noise/break reporting and false-start rejection.
module uart_rx_os #(
    parameter  int OSR        = 16,
    parameter  int MAX_DATA_W = 9,
    localparam int DBW        = $clog2(MAX_DATA_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  rx,
    input  logic [DBW-1:0]        data_bits,
    input  logic                  stop_bit_num,
    input  logic                  parity_en,
    input  logic                  parity_type,
    output logic                  busy,
    output logic                  rx_valid,
    output logic [MAX_DATA_W-1:0] rx_data,
    output logic                  parity_error,
    output logic                  framing_error,
    output logic                  noise_error,
    output logic                  break_detect
);
    localparam int TW = $clog2(OSR);
    localparam logic [TW-1:0]  T_LO   = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0]  T_MID  = TW'(OSR / 2);
    localparam logic [TW-1:0]  T_HI   = TW'(OSR / 2 + 1);
    localparam logic [TW-1:0]  T_LAST = TW'(OSR - 1);
    localparam logic [DBW-1:0] MIN_BITS = DBW'(5);
    localparam logic [DBW-1:0] MAX_BITS = DBW'(MAX_DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t                state;
    logic                  rx_meta;
    logic                  rx_s;
    logic [TW-1:0]         tcnt;
    logic [DBW-1:0]        bit_idx;
    logic [DBW-1:0]        nbits_q;
    logic                  two_stop_q;
    logic                  par_en_q;
    logic                  par_odd_q;
    logic                  stop_idx;
    logic [1:0]            samp;
    logic [MAX_DATA_W-1:0] shadow;
    logic                  acc;
    logic                  noise_f;
    logic                  parity_f;
    logic                  framing_f;
    logic                  all_zero;

    logic                  maj;
    logic                  noisy;
    logic                  mid;
    logic                  last;
    logic                  final_stop;
    logic [DBW-1:0]        nbits_clamped;

    // The third sample is the live rx_s on the deciding tick, so the vote needs no extra register.
    assign maj   = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign noisy = !((samp[0] == samp[1]) && (samp[1] == rx_s));
    assign mid   = (tcnt == T_HI);
    assign last  = (tcnt == T_LAST);
    assign final_stop = !two_stop_q || stop_idx;
    assign nbits_clamped = (data_bits < MIN_BITS) ? MIN_BITS :
                           (data_bits > MAX_BITS) ? MAX_BITS : data_bits;
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            tcnt          <= '0;
            bit_idx       <= '0;
            nbits_q       <= '0;
            two_stop_q    <= 1'b0;
            par_en_q      <= 1'b0;
            par_odd_q     <= 1'b0;
            stop_idx      <= 1'b0;
            samp          <= '0;
            shadow        <= '0;
            acc           <= 1'b0;
            noise_f       <= 1'b0;
            parity_f      <= 1'b0;
            framing_f     <= 1'b0;
            all_zero      <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            noise_error   <= 1'b0;
            break_detect  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (tick) begin
                if (state != IDLE && state != BRK_WAIT) begin
                    tcnt <= last ? '0 : tcnt + 1'b1;
                    if (tcnt == T_LO)  samp[0] <= rx_s;
                    if (tcnt == T_MID) samp[1] <= rx_s;
                    if (mid && noisy)  noise_f <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state      <= START;
                            tcnt       <= '0;
                            bit_idx    <= '0;
                            stop_idx   <= 1'b0;
                            nbits_q    <= nbits_clamped;
                            two_stop_q <= stop_bit_num;
                            par_en_q   <= parity_en;
                            par_odd_q  <= parity_type;
                            shadow     <= '0;
                            acc        <= 1'b0;
                            noise_f    <= 1'b0;
                            parity_f   <= 1'b0;
                            framing_f  <= 1'b0;
                            all_zero   <= 1'b1;
                        end
                    end
                    START: begin
                        if (mid && maj) begin
                            state <= IDLE;
                            tcnt  <= '0;
                        end else if (last) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (mid) begin
                            shadow[bit_idx] <= maj;
                            acc             <= acc ^ maj;
                            if (maj) all_zero <= 1'b0;
                        end
                        if (last) begin
                            if (bit_idx == nbits_q - 1'b1) begin
                                bit_idx <= '0;
                                state   <= par_en_q ? PARITY : STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        if (mid) begin
                            if (maj != (acc ^ par_odd_q)) parity_f <= 1'b1;
                            if (maj) all_zero <= 1'b0;
                        end
                        if (last) state <= STOP;
                    end
                    STOP: begin
                        // The final stop bit finishes at mid-bit so the next start edge is not missed.
                        if (mid && final_stop) begin
                            rx_valid      <= 1'b1;
                            rx_data       <= shadow;
                            parity_error  <= parity_f;
                            framing_error <= framing_f | ~maj;
                            noise_error   <= noise_f | noisy;
                            break_detect  <= all_zero & ~maj;
                            state         <= (all_zero & ~maj) ? BRK_WAIT : IDLE;
                            tcnt          <= '0;
                        end else begin
                            if (mid && !maj) framing_f <= 1'b1;
                            if (last) stop_idx <= 1'b1;
                        end
                    end
                    BRK_WAIT: begin
                        if (rx_s) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: directed frames push expected results, a negedge monitor
// pops and compares on every rx_valid pulse.
module tb_uart_rx_os;
    localparam int OSR        = 16;
    localparam int MAX_DATA_W = 9;
    localparam int DBW        = $clog2(MAX_DATA_W + 1);

    typedef struct {
        logic [MAX_DATA_W-1:0] data;
        logic                  pe;
        logic                  fe;
        logic                  ne;
        logic                  bd;
        logic                  busy;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  tick;
    logic                  rx = 1'b1;
    logic [DBW-1:0]        data_bits = DBW'(8);
    logic                  stop_bit_num = 1'b0;
    logic                  parity_en = 1'b0;
    logic                  parity_type = 1'b0;
    logic                  busy;
    logic                  rx_valid;
    logic [MAX_DATA_W-1:0] rx_data;
    logic                  parity_error;
    logic                  framing_error;
    logic                  noise_error;
    logic                  break_detect;

    logic [1:0] tick_div = 2'd0;
    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         valid_count = 0;
    int         exp_total = 0;
    logic       prev_valid = 1'b0;

    uart_rx_os #(.OSR(OSR), .MAX_DATA_W(MAX_DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .rx           (rx),
        .data_bits    (data_bits),
        .stop_bit_num (stop_bit_num),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .busy         (busy),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .noise_error  (noise_error),
        .break_detect (break_detect)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tick_div <= tick_div + 2'd1;
    assign tick = (tick_div == 2'd3);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input logic [MAX_DATA_W-1:0] data, input logic pe, input logic fe,
                              input logic ne, input logic bd, input logic bsy);
        exp_t e;
        e.data = data; e.pe = pe; e.fe = fe; e.ne = ne; e.bd = bd; e.busy = bsy;
        exp_q.push_back(e);
        exp_total++;
    endtask

    task automatic wait_tick();
        @(posedge clk iff tick);
        #1;
    endtask

    task automatic drive_bit(input logic val, input int glitch_at);
        for (int t = 0; t < OSR; t++) begin
            rx = (t == glitch_at) ? 1'b0 : val;
            wait_tick();
        end
    endtask

    task automatic applyStimulus(input logic [MAX_DATA_W-1:0] data, input int nbits, input bit has_par,
                                 input bit par_bit, input int nstop, input bit stop_val,
                                 input int glitch_bit, input int glitch_tick);
        drive_bit(1'b0, -1);
        for (int i = 0; i < nbits; i++)
            drive_bit(data[i], (i == glitch_bit) ? glitch_tick : -1);
        if (has_par) drive_bit(par_bit, -1);
        for (int s = 0; s < nstop; s++) drive_bit(stop_val, -1);
        rx = 1'b1;
        repeat (20) wait_tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rx_valid === 1'b1) begin
            valid_count++;
            if (prev_valid) checkOutput("rx_valid_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rx_valid: got rx_data 0x%0h, expected no frame", rx_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rx_data", 32'(rx_data), 32'(e.data));
                checkOutput("parity_error", 32'(parity_error), 32'(e.pe));
                checkOutput("framing_error", 32'(framing_error), 32'(e.fe));
                checkOutput("noise_error", 32'(noise_error), 32'(e.ne));
                checkOutput("break_detect", 32'(break_detect), 32'(e.bd));
                checkOutput("busy_at_valid", 32'(busy), 32'(e.busy));
            end
        end
        prev_valid = (rx_valid === 1'b1);
    end

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        checkOutput({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        checkOutput({tag, "_parity_error"}, 32'(parity_error), 32'd0);
        checkOutput({tag, "_framing_error"}, 32'(framing_error), 32'd0);
        checkOutput({tag, "_noise_error"}, 32'(noise_error), 32'd0);
        checkOutput({tag, "_break_detect"}, 32'(break_detect), 32'd0);
    endtask

    initial begin
        $display("[TB] starting uart_rx_os bench");
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) wait_tick();

        // 8N1 0xA5
        pushExpect(9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, -1, 0);

        // 7E1 0x41 with wrong then correct parity
        data_bits = DBW'(7); parity_en = 1'b1; parity_type = 1'b0;
        pushExpect(9'h041, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h041, 7, 1'b1, 1'b1, 1, 1'b1, -1, 0);
        pushExpect(9'h041, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h041, 7, 1'b1, 1'b0, 1, 1'b1, -1, 0);

        // false start: 5 low ticks
        data_bits = DBW'(8); parity_en = 1'b0;
        rx = 1'b0;
        repeat (3) wait_tick();
        checkOutput("false_start_busy_high", 32'(busy), 32'd1);
        repeat (2) wait_tick();
        rx = 1'b1;
        repeat (8) wait_tick();
        checkOutput("false_start_busy_low", 32'(busy), 32'd0);
        repeat (10) wait_tick();
        pushExpect(9'h03C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, -1, 0);

        // framing error: stop bit forced low
        pushExpect(9'h055, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h055, 8, 1'b0, 1'b0, 1, 1'b0, -1, 0);

        // break: 25 bit times low, then recovery
        pushExpect(9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        rx = 1'b0;
        repeat (25 * OSR) wait_tick();
        checkOutput("break_busy_held", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (20) wait_tick();
        checkOutput("break_release_busy", 32'(busy), 32'd0);
        pushExpect(9'h081, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h081, 8, 1'b0, 1'b0, 1, 1'b1, -1, 0);

        // 9N2 0x1FF with a one-tick glitch mid data bit 3
        data_bits = DBW'(9); stop_bit_num = 1'b1;
        pushExpect(9'h1FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(9'h1FF, 9, 1'b0, 1'b0, 2, 1'b1, 3, 9);

        // reset in the middle of a frame
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        drive_bit(1'b0, -1);
        drive_bit(1'b1, -1);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        check_reset_state("midframe_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) wait_tick();
        pushExpect(9'h12D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h12D, 9, 1'b0, 1'b0, 2, 1'b1, -1, 0);

        // data_bits below 5 behaves as 5
        data_bits = DBW'(3); stop_bit_num = 1'b0;
        pushExpect(9'h015, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h015, 5, 1'b0, 1'b0, 1, 1'b1, -1, 0);

        repeat (10) wait_tick();
        checkOutput("pending_expected_frames", 32'(exp_q.size()), 32'd0);
        checkOutput("rx_valid_count", 32'(valid_count), 32'(exp_total));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
